// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    REPORT   = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } state_e;

  localparam int unsigned KEY_W = 4;
  localparam logic [3:0]  COL_RESET = 4'b1110;

  // Key codes indexed by {row, col}; entry 0 sits in the least significant nibble.
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } low_dec_t;

  function automatic low_dec_t low_index(input logic [3:0] pat);
    low_dec_t d;
    d.valid = 1'b1;
    d.idx   = 2'd0;
    case (pat)
      4'b1110: d.idx = 2'd0;
      4'b1101: d.idx = 2'd1;
      4'b1011: d.idx = 2'd2;
      4'b0111: d.idx = 2'd3;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [KEY_W-1:0] key_code(input logic [3:0] key_idx);
    return KEY_MAP[6'({key_idx, 2'b00}) +: 4];
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous keypad row lines; data only, no reset.
module keypad_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row debounce and key encoding.
// Optional auto-repeat while a key is held is enabled by KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 200000,
  parameter int unsigned REPEAT_CNT   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] keyboard_num,
  output logic       keyboard_en
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0] row_s;

  keypad_sync #(.W(4)) u_sync (
    .clk (clk),
    .d_i (row_n),
    .q_o (row_s)
  );

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [3:0]       key_idx_q, key_idx_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       num_q, num_d;
  logic             en_q, en_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CNT);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  low_dec_t rdec;
  low_dec_t cdec;
  logic     div_end;
  logic     deb_end;
  logic     pat_match;
  logic     all_high;

  assign rdec      = low_index(row_s);
  assign cdec      = low_index(col_n_q);
  assign div_end   = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign deb_end   = (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1));
  assign pat_match = (row_s == pat_q);
  assign all_high  = (row_s == 4'hF);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    deb_cnt_d = deb_cnt_q;
    col_n_d   = col_n_q;
    key_idx_d = key_idx_q;
    pat_d     = pat_q;
    num_d     = num_q;
    en_d      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif

    case (state_q)
      SCAN: begin
        if (div_end) begin
          div_cnt_d = '0;
          if (rdec.valid && cdec.valid) begin
            key_idx_d = {rdec.idx, cdec.idx};
            pat_d     = row_s;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_n_d = {col_n_q[2:0], col_n_q[3]};
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      DEBOUNCE: begin
        if (!pat_match) begin
          deb_cnt_d = '0;
          div_cnt_d = '0;
          col_n_d   = {col_n_q[2:0], col_n_q[3]};
          state_d   = SCAN;
        end else if (deb_end) begin
          deb_cnt_d = '0;
          num_d     = key_code(key_idx_q);
          en_d      = 1'b1;
          state_d   = REPORT;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      REPORT: begin
        state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d = '0;
`endif
      end

      HOLD: begin
        if (all_high) begin
          deb_cnt_d = '0;
          state_d   = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat pulse lands the cycle after the terminal count, like the first report.
        else if (rep_cnt_q == REP_W'(REPEAT_CNT - 1)) begin
          rep_cnt_d = '0;
          en_d      = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
`endif
      end

      RELEASE: begin
        if (!all_high) begin
          deb_cnt_d = '0;
          state_d   = HOLD;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else if (deb_end) begin
          deb_cnt_d = '0;
          div_cnt_d = '0;
          col_n_d   = {col_n_q[2:0], col_n_q[3]};
          state_d   = SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      default: begin
        state_d   = SCAN;
        div_cnt_d = '0;
        deb_cnt_d = '0;
        col_n_d   = COL_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      div_cnt_q <= '0;
      deb_cnt_q <= '0;
      col_n_q   <= COL_RESET;
      key_idx_q <= '0;
      pat_q     <= 4'hF;
      num_q     <= 4'h0;
      en_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      deb_cnt_q <= deb_cnt_d;
      col_n_q   <= col_n_d;
      key_idx_q <= key_idx_d;
      pat_q     <= pat_d;
      num_q     <= num_d;
      en_q      <= en_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  assign col_n        = col_n_q;
  assign keyboard_num = num_q;
  assign keyboard_en  = en_q;

endmodule
